sse_frame_ctrl: RTL and testbench
=================================

Name: sse_frame_ctrl

Overview:
Frame sequencer for the ScaleSpaceExtrema datapath, replacing direct host poking of the SSE reset and select inputs.
- Host writes a small byte-wide register file over the mem_8 style port, then sets START.
- The block then:
  - pulses the SSE reset;
  - hands the select byte over a valid/ready handshake;
  - admits exactly FRAME_LEN pixels from the input FIFO;
  - counts FRAME_LEN pixels into the output FIFO;
  - reports done/error status and a completed-frame counter.

Parameters:
RESET_CYCLES, 4, cycles sse_reset is held high in RESET state (>=1)
LEN_W, 16, width of frame length and pixel counters
WDOG_CYCLES, 65535, stall limit in STREAM when SSE_CTRL_WDOG_EN is defined

Ports:
bus_clk  in  1  sole clock
reset_n  in  1  asynchronous, active-low reset
cfg_wren  in  1  register write strobe
cfg_rden  in  1  register read strobe
cfg_addr  in  3  register address
cfg_wdata  in  8  write data
cfg_rdata  out  8  read data, registered
sse_reset  out  1  reset to ScaleSpaceExtrema
sse_select_valid  out  1  select handshake valid
sse_select_ready  in  1  select handshake ready
sse_select_bits  out  8  selected stream
src_valid  in  1  input FWFT FIFO has data
src_rden  out  1  input FIFO pop
sse_in_valid  out  1  gated valid to SSE
sse_in_ready  in  1  SSE accepts pixel
sse_out_valid  in  1  SSE output valid
sse_out_ready  out  1  to SSE
dst_full  in  1  output FIFO full
dst_wren  out  1  output FIFO push
busy  out  1  state != IDLE

Behaviour:
Registers, all reset to 0:
- 0 CTRL (write-only; reads 0):
  - bit0 START: one-cycle pulse; ignored unless IDLE.
  - bit1 ABORT: one-cycle pulse; any state -> RESET, then IDLE; counters cleared; no frame counted.
- 1 SELECT.
- 2 LEN_LO, 3 LEN_HI: shadow registers. Writable anytime; latched into the working length only at START.
- 4 STATUS (read-only): bit0 busy, bit1 done (sticky), bit2 len_err, bit3 overflow, bit4 timeout. Bits 1-4 are cleared by START.
- 5 FRAME_CNT: +1 per completed frame; wraps 255->0.
- 6 OUT_CNT_LO, 7 OUT_CNT_HI: live output pixel count.

Register read/write timing:
- cfg_rdata updates the cycle after cfg_rden; otherwise it holds its value.
- Write and read to the same address in the same cycle: the read returns the old value.

State machine (reset to IDLE):
- IDLE:
  - START with length 0: set len_err, stay IDLE.
  - Otherwise: latch length, clear in_cnt/out_cnt -> RESET.
- RESET: sse_reset=1 for exactly RESET_CYCLES cycles -> SELECT.
- SELECT: sse_select_valid=1, sse_select_bits=SELECT (sampled at START). Leave on the first cycle with valid&ready -> STREAM.
- STREAM, input side:
  - sse_in_valid = src_valid & (in_cnt < len).
  - src_rden = sse_in_valid & sse_in_ready.
  - in_cnt increments on each src_rden.
  - Once in_cnt == len, the input FIFO is never popped again.
- STREAM, output side:
  - sse_out_ready = !dst_full.
  - dst_wren = sse_out_valid & !dst_full & (out_cnt < len).
  - out_cnt increments on each dst_wren.
  - A beat accepted when out_cnt == len is discarded and sets overflow.
- STREAM exit: when in_cnt == len and out_cnt == len -> DONE.
- DONE: one cycle; set done, FRAME_CNT+1 -> IDLE.

Other rules:
- Outside STREAM: sse_in_valid, src_rden and dst_wren are 0; sse_out_ready = 1 (drains and discards).
- Async reset: all outputs 0, sse_reset included; cfg_rdata = 0. No state survives reset.
- ABORT and START in the same write: ABORT wins.
- Counters are LEN_W bits; length is at most 2^LEN_W-1, so counters never wrap.

Optional Feature:
SSE_CTRL_WDOG_EN
- Defined:
  - A stall counter runs in STREAM: cleared on any src_rden or dst_wren, otherwise increments.
  - On reaching WDOG_CYCLES: set timeout -> RESET -> IDLE, with no frame counted and done not set.
- Undefined: no stall counter; STATUS bit4 reads 0; STREAM waits indefinitely.

Test Plan:
1. LEN=16, SELECT=8, START; SSE ready always; src/dst never stall.
   -> sse_reset high 4 cycles; one select handshake with bits=8; 16 src_rden; 16 dst_wren; done=1; FRAME_CNT=1.
2. LEN=0, START.
   -> len_err=1, busy stays 0, no sse_reset pulse.
3. LEN=8; SSE emits 10 output beats.
   -> dst_wren exactly 8; overflow=1; done=1.
4. LEN=100; dst_full asserted for 50 cycles mid-frame.
   -> sse_out_ready=0 during the stall; final OUT_CNT=100; no beats lost.
5. ABORT after 5 pixels of LEN=20.
   -> RESET 4 cycles, then IDLE; FRAME_CNT unchanged; START then runs a full 20-pixel frame.
6. (WDOG, WDOG_CYCLES=32) src_valid held 0 in STREAM.
   -> timeout=1 after 32 idle cycles; returns to IDLE; done=0.

Source files
------------

// File: rtl/sse_frame_ctrl_if.sv
// Host register port and SSE/FIFO handshake bundle for sse_frame_ctrl.
// master: host/environment side, slave: the controller.
interface sse_frame_ctrl_if;
  logic       cfg_wren;
  logic       cfg_rden;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;
  logic       sse_reset;
  logic       sse_select_valid;
  logic       sse_select_ready;
  logic [7:0] sse_select_bits;
  logic       src_valid;
  logic       src_rden;
  logic       sse_in_valid;
  logic       sse_in_ready;
  logic       sse_out_valid;
  logic       sse_out_ready;
  logic       dst_full;
  logic       dst_wren;
  logic       busy;

  modport master (
    output cfg_wren, cfg_rden, cfg_addr, cfg_wdata,
    input  cfg_rdata,
    input  sse_reset, sse_select_valid, sse_select_bits,
    output sse_select_ready,
    output src_valid, sse_in_ready, sse_out_valid, dst_full,
    input  src_rden, sse_in_valid, sse_out_ready, dst_wren,
    input  busy
  );

  modport slave (
    input  cfg_wren, cfg_rden, cfg_addr, cfg_wdata,
    output cfg_rdata,
    output sse_reset, sse_select_valid, sse_select_bits,
    input  sse_select_ready,
    input  src_valid, sse_in_ready, sse_out_valid, dst_full,
    output src_rden, sse_in_valid, sse_out_ready, dst_wren,
    output busy
  );
endinterface

// File: rtl/sse_frame_ctrl.sv
// Frame sequencer for ScaleSpaceExtrema: reset, select, stream FRAME_LEN.
// Optional stall watchdog enabled by defining SSE_CTRL_WDOG_EN.
module sse_frame_ctrl #(
  parameter int RESET_CYCLES = 4,
  parameter int LEN_W        = 16,
  parameter int WDOG_CYCLES  = 65535
) (
  input  logic            bus_clk,
  input  logic            reset_n,
  sse_frame_ctrl_if.slave io
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_SELECT,
    S_STREAM,
    S_DONE
  } state_t;

  localparam int RC_W = $clog2(RESET_CYCLES + 1);

  state_t           state_q, state_d;
  logic [7:0]       sel_q, sel_lat_q;
  logic [7:0]       len_lo_q, len_hi_q;
  logic [7:0]       frame_cnt_q, rdata_q, rd_mux;
  logic [LEN_W-1:0] len_q, len_shadow;
  logic [LEN_W-1:0] in_cnt_q, out_cnt_q;
  logic [15:0]      out_cnt16;
  logic [RC_W-1:0]  rst_cnt_q;
  logic             done_q, len_err_q, ovf_q, tmo_q;
  logic             idle_ret_q, run_q;
  logic             wr_ctrl, abort, start, start_idle, go;
  logic             streaming, in_room, out_room;
  logic             rden, wren, ovf_hit, frame_end;
  logic             stall_hit, wd_trip, rst_last;

  assign wr_ctrl    = io.cfg_wren && (io.cfg_addr == 3'd0);
  assign abort      = wr_ctrl && io.cfg_wdata[1];
  assign start      = wr_ctrl && io.cfg_wdata[0]
                   && !io.cfg_wdata[1];
  assign start_idle = start && (state_q == S_IDLE);
  assign len_shadow = LEN_W'({len_hi_q, len_lo_q});
  assign go         = start_idle && (len_shadow != '0);

  assign streaming  = (state_q == S_STREAM);
  assign in_room    = (in_cnt_q < len_q);
  assign out_room   = (out_cnt_q < len_q);
  assign rst_last   = (rst_cnt_q == RC_W'(RESET_CYCLES - 1));

  assign io.sse_in_valid = streaming && io.src_valid && in_room;
  assign rden    = io.sse_in_valid && io.sse_in_ready;
  assign wren    = streaming && io.sse_out_valid
                && !io.dst_full && out_room;
  assign ovf_hit = streaming && io.sse_out_valid
                && !io.dst_full && !out_room;
  assign frame_end = streaming && !in_room && !out_room;
  assign wd_trip   = stall_hit && !frame_end && !abort;

  // run_q keeps out_ready low while reset is held
  assign io.sse_out_ready = run_q
                         && (streaming ? !io.dst_full : 1'b1);
  assign io.src_rden        = rden;
  assign io.dst_wren        = wren;
  assign io.sse_reset       = (state_q == S_RESET);
  assign io.sse_select_valid = (state_q == S_SELECT);
  assign io.sse_select_bits = sel_lat_q;
  assign io.busy            = (state_q != S_IDLE);
  assign io.cfg_rdata       = rdata_q;
  assign out_cnt16          = 16'(out_cnt_q);

`ifdef SSE_CTRL_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] stall_q;

  always_ff @(posedge bus_clk or negedge reset_n) begin
    if (!reset_n)
      stall_q <= '0;
    else if (!streaming || rden || wren)
      stall_q <= '0;
    else
      stall_q <= stall_q + 1'b1;
  end

  assign stall_hit = streaming && !rden && !wren
                  && (stall_q == WD_W'(WDOG_CYCLES - 1));
`else
  assign stall_hit = 1'b0;
`endif

  always_ff @(posedge bus_clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_RESET;
    end else begin
      unique case (state_q)
        S_IDLE:
          if (go) state_d = S_RESET;
        S_RESET:
          if (rst_last)
            state_d = idle_ret_q ? S_IDLE : S_SELECT;
        S_SELECT:
          if (io.sse_select_ready) state_d = S_STREAM;
        S_STREAM:
          if (frame_end)      state_d = S_DONE;
          else if (stall_hit) state_d = S_RESET;
        S_DONE:
          state_d = S_IDLE;
        default:
          state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (io.cfg_addr)
      3'd1: rd_mux = sel_q;
      3'd2: rd_mux = len_lo_q;
      3'd3: rd_mux = len_hi_q;
      3'd4: rd_mux = {3'b000, tmo_q, ovf_q,
                      len_err_q, done_q, io.busy};
      3'd5: rd_mux = frame_cnt_q;
      3'd6: rd_mux = out_cnt16[7:0];
      3'd7: rd_mux = out_cnt16[15:8];
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge bus_clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q       <= 1'b0;
      sel_q       <= '0;
      sel_lat_q   <= '0;
      len_lo_q    <= '0;
      len_hi_q    <= '0;
      len_q       <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      rst_cnt_q   <= '0;
      idle_ret_q  <= 1'b0;
      done_q      <= 1'b0;
      len_err_q   <= 1'b0;
      ovf_q       <= 1'b0;
      tmo_q       <= 1'b0;
      frame_cnt_q <= '0;
      rdata_q     <= '0;
    end else begin
      run_q <= 1'b1;

      if (io.cfg_wren && io.cfg_addr == 3'd1)
        sel_q <= io.cfg_wdata;
      if (io.cfg_wren && io.cfg_addr == 3'd2)
        len_lo_q <= io.cfg_wdata;
      if (io.cfg_wren && io.cfg_addr == 3'd3)
        len_hi_q <= io.cfg_wdata;

      if (state_q != S_RESET || abort)
        rst_cnt_q <= '0;
      else
        rst_cnt_q <= rst_cnt_q + 1'b1;

      // abort and watchdog both park in IDLE after RESET
      if (abort || wd_trip)
        idle_ret_q <= 1'b1;
      else if (state_q == S_RESET && rst_last)
        idle_ret_q <= 1'b0;

      if (abort || go) begin
        in_cnt_q  <= '0;
        out_cnt_q <= '0;
      end else begin
        if (rden) in_cnt_q  <= in_cnt_q + 1'b1;
        if (wren) out_cnt_q <= out_cnt_q + 1'b1;
      end

      if (go) begin
        len_q     <= len_shadow;
        sel_lat_q <= sel_q;
      end

      if (start_idle) begin
        done_q    <= 1'b0;
        ovf_q     <= 1'b0;
        tmo_q     <= 1'b0;
        len_err_q <= (len_shadow == '0);
      end else begin
        if (state_q == S_DONE && !abort) begin
          done_q      <= 1'b1;
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end
        if (ovf_hit) ovf_q <= 1'b1;
        if (wd_trip) tmo_q <= 1'b1;
      end

      if (io.cfg_rden)
        rdata_q <= rd_mux;
    end
  end

endmodule

// File: tb/tb_sse_frame_ctrl.sv
// Directed testbench for sse_frame_ctrl.
// Build with SSE_CTRL_WDOG_EN defined to exercise the watchdog.
module tb_sse_frame_ctrl;

  logic bus_clk;
  logic reset_n;
  int   n_cmp;
  int   n_fail;

  int n_rst, n_busy, n_rden, n_wren, n_sel;
  int b_rst, b_busy, b_rden, b_wren, b_sel;
  logic [7:0] sel_seen;

  sse_frame_ctrl_if io ();

  sse_frame_ctrl #(
    .RESET_CYCLES(4),
    .LEN_W(16),
    .WDOG_CYCLES(32)
  ) dut (
    .bus_clk(bus_clk),
    .reset_n(reset_n),
    .io(io.slave)
  );

  initial begin
    bus_clk = 1'b0;
    forever #5 bus_clk = ~bus_clk;
  end

  always @(negedge bus_clk) begin
    if (reset_n) begin
      if (io.sse_reset) n_rst++;
      if (io.busy) n_busy++;
      if (io.src_rden) n_rden++;
      if (io.dst_wren) n_wren++;
      if (io.sse_select_valid && io.sse_select_ready) begin
        n_sel++;
        sel_seen = io.sse_select_bits;
      end
    end
  end

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic mark();
    b_rst  = n_rst;
    b_busy = n_busy;
    b_rden = n_rden;
    b_wren = n_wren;
    b_sel  = n_sel;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    io.cfg_wren  = 1'b1;
    io.cfg_addr  = a;
    io.cfg_wdata = d;
    tick();
    io.cfg_wren  = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    io.cfg_rden = 1'b1;
    io.cfg_addr = a;
    tick();
    io.cfg_rden = 1'b0;
    d = io.cfg_rdata;
  endtask

  task automatic wait_select();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (io.sse_select_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL select_wait: got no select, want select");
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!io.busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL idle_wait: busy stuck, want idle");
    end
  endtask

  task automatic stream(
    input  int in_n,
    input  int in_at,
    input  int out_n,
    input  int st_at,
    input  int st_len,
    output int got_in,
    output int got_out,
    output int rdy_bad
  );
    got_in  = 0;
    got_out = 0;
    rdy_bad = 0;
    for (int c = 0; c < 600; c++) begin
      if (got_in >= in_n && got_out >= out_n) break;
      io.src_valid     = (c >= in_at) && (got_in < in_n);
      io.sse_out_valid = (got_out < out_n);
      io.dst_full      = (c >= st_at) && (c < st_at + st_len);
      #1;
      if (io.src_rden) got_in++;
      if (io.sse_out_valid && io.sse_out_ready) got_out++;
      if (io.dst_full && io.sse_out_ready) rdy_bad++;
      tick();
    end
    io.src_valid     = 1'b0;
    io.sse_out_valid = 1'b0;
    io.dst_full      = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset_n = 1'b1;
    #2;
    reset_n = 1'b0;
    repeat (2) @(posedge bus_clk);
    #1;
    n_cmp++;
    if ({io.sse_reset, io.sse_select_valid, io.src_rden,
         io.sse_in_valid, io.sse_out_ready, io.dst_wren,
         io.busy} !== 7'b0) begin
      n_fail++;
      $display("FAIL rst_outputs: got nonzero, want 0");
    end
    n_cmp++;
    if (io.cfg_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_rdata: got %0h want 0", io.cfg_rdata);
    end
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (io.sse_out_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_drain: got %0b want 1",
               io.sse_out_ready);
    end
    rd(3'd4, d);
    n_cmp++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_status: got %0h want 0", d);
    end
    rd(3'd5, d);
    n_cmp++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_frame: got %0h want 0", d);
    end
  endtask

  task automatic test_regs();
    logic [7:0] d;
    io.cfg_wren  = 1'b1;
    io.cfg_rden  = 1'b1;
    io.cfg_addr  = 3'd1;
    io.cfg_wdata = 8'h5A;
    tick();
    io.cfg_wren = 1'b0;
    io.cfg_rden = 1'b0;
    n_cmp++;
    if (io.cfg_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL rw_same: got %0h want 0", io.cfg_rdata);
    end
    tick();
    n_cmp++;
    if (io.cfg_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL rd_hold: got %0h want 0", io.cfg_rdata);
    end
    rd(3'd1, d);
    n_cmp++;
    if (d !== 8'h5A) begin
      n_fail++;
      $display("FAIL sel_rb: got %0h want 5a", d);
    end
    wr(3'd3, 8'hA5);
    rd(3'd3, d);
    n_cmp++;
    if (d !== 8'hA5) begin
      n_fail++;
      $display("FAIL lenhi_rb: got %0h want a5", d);
    end
    rd(3'd0, d);
    n_cmp++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL ctrl_rb: got %0h want 0", d);
    end
    wr(3'd3, 8'h00);
  endtask

  task automatic test_basic();
    logic [7:0] d;
    int gi, go, rb;
    wr(3'd2, 8'd16);
    wr(3'd3, 8'd0);
    wr(3'd1, 8'd8);
    mark();
    wr(3'd0, 8'h01);
    wait_select();
    stream(16, 0, 16, 999, 0, gi, go, rb);
    wait_idle();
    n_cmp++;
    if (n_rst - b_rst !== 4) begin
      n_fail++;
      $display("FAIL b_rst: got %0d want 4", n_rst - b_rst);
    end
    n_cmp++;
    if (n_sel - b_sel !== 1 || sel_seen !== 8'd8) begin
      n_fail++;
      $display("FAIL b_sel: got %0d/%0h want 1/8",
               n_sel - b_sel, sel_seen);
    end
    n_cmp++;
    if (n_rden - b_rden !== 16) begin
      n_fail++;
      $display("FAIL b_rden: got %0d want 16", n_rden - b_rden);
    end
    n_cmp++;
    if (n_wren - b_wren !== 16) begin
      n_fail++;
      $display("FAIL b_wren: got %0d want 16", n_wren - b_wren);
    end
    rd(3'd4, d);
    n_cmp++;
    if (d !== 8'h02) begin
      n_fail++;
      $display("FAIL b_status: got %0h want 02", d);
    end
    rd(3'd5, d);
    n_cmp++;
    if (d !== 8'd1) begin
      n_fail++;
      $display("FAIL b_frame: got %0d want 1", d);
    end
    rd(3'd6, d);
    n_cmp++;
    if (d !== 8'd16) begin
      n_fail++;
      $display("FAIL b_outcnt: got %0d want 16", d);
    end
  endtask

  task automatic test_len_zero();
    logic [7:0] d;
    wr(3'd2, 8'd0);
    wr(3'd3, 8'd0);
    mark();
    wr(3'd0, 8'h01);
    repeat (8) tick();
    rd(3'd4, d);
    n_cmp++;
    if (d !== 8'h04) begin
      n_fail++;
      $display("FAIL z_status: got %0h want 04", d);
    end
    n_cmp++;
    if (n_busy - b_busy !== 0 || n_rst - b_rst !== 0) begin
      n_fail++;
      $display("FAIL z_idle: got busy %0d rst %0d want 0/0",
               n_busy - b_busy, n_rst - b_rst);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    int gi, go, rb;
    wr(3'd2, 8'd8);
    mark();
    wr(3'd0, 8'h01);
    wait_select();
    stream(8, 12, 10, 999, 0, gi, go, rb);
    wait_idle();
    n_cmp++;
    if (n_wren - b_wren !== 8 || go !== 10) begin
      n_fail++;
      $display("FAIL o_wren: got %0d of %0d want 8 of 10",
               n_wren - b_wren, go);
    end
    rd(3'd4, d);
    n_cmp++;
    if (d !== 8'h0A) begin
      n_fail++;
      $display("FAIL o_status: got %0h want 0a", d);
    end
    rd(3'd5, d);
    n_cmp++;
    if (d !== 8'd2) begin
      n_fail++;
      $display("FAIL o_frame: got %0d want 2", d);
    end
  endtask

  task automatic test_stall();
    logic [7:0] d;
    int gi, go, rb;
    wr(3'd2, 8'd100);
    mark();
    wr(3'd0, 8'h01);
    wait_select();
    stream(100, 0, 100, 30, 50, gi, go, rb);
    wait_idle();
    n_cmp++;
    if (rb !== 0) begin
      n_fail++;
      $display("FAIL s_ready: got %0d ready cycles want 0", rb);
    end
    n_cmp++;
    if (n_wren - b_wren !== 100 || go !== 100) begin
      n_fail++;
      $display("FAIL s_wren: got %0d/%0d want 100/100",
               n_wren - b_wren, go);
    end
    rd(3'd6, d);
    n_cmp++;
    if (d !== 8'd100) begin
      n_fail++;
      $display("FAIL s_outlo: got %0d want 100", d);
    end
    rd(3'd7, d);
    n_cmp++;
    if (d !== 8'd0) begin
      n_fail++;
      $display("FAIL s_outhi: got %0d want 0", d);
    end
    rd(3'd4, d);
    n_cmp++;
    if (d !== 8'h02) begin
      n_fail++;
      $display("FAIL s_status: got %0h want 02", d);
    end
  endtask

  task automatic test_abort();
    logic [7:0] d;
    int gi, go, rb;
    wr(3'd2, 8'd20);
    wr(3'd0, 8'h01);
    wait_select();
    stream(5, 0, 3, 999, 0, gi, go, rb);
    mark();
    wr(3'd0, 8'h02);
    wait_idle();
    n_cmp++;
    if (n_rst - b_rst !== 4 || n_sel - b_sel !== 0) begin
      n_fail++;
      $display("FAIL a_rst: got rst %0d sel %0d want 4/0",
               n_rst - b_rst, n_sel - b_sel);
    end
    rd(3'd5, d);
    n_cmp++;
    if (d !== 8'd3) begin
      n_fail++;
      $display("FAIL a_frame: got %0d want 3", d);
    end
    rd(3'd6, d);
    n_cmp++;
    if (d !== 8'd0) begin
      n_fail++;
      $display("FAIL a_outcnt: got %0d want 0", d);
    end
    rd(3'd4, d);
    n_cmp++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL a_status: got %0h want 00", d);
    end
    mark();
    wr(3'd0, 8'h01);
    wait_select();
    stream(20, 0, 20, 999, 0, gi, go, rb);
    wait_idle();
    n_cmp++;
    if (n_rden - b_rden !== 20 || n_wren - b_wren !== 20) begin
      n_fail++;
      $display("FAIL a_rerun: got %0d/%0d want 20/20",
               n_rden - b_rden, n_wren - b_wren);
    end
    mark();
    wr(3'd0, 8'h03);
    wait_idle();
    rd(3'd5, d);
    n_cmp++;
    if (d !== 8'd4 || n_sel - b_sel !== 0
        || n_rst - b_rst !== 4) begin
      n_fail++;
      $display("FAIL a_both: got frame %0d sel %0d rst %0d want 4/0/4",
               d, n_sel - b_sel, n_rst - b_rst);
    end
  endtask

  task automatic test_wdog();
    logic [7:0] d;
    int k;
    wr(3'd2, 8'd4);
    wr(3'd0, 8'h01);
    wait_select();
    k = 0;
`ifdef SSE_CTRL_WDOG_EN
    for (int i = 0; i < 100; i++) begin
      if (io.sse_reset) break;
      tick();
      k++;
    end
    n_cmp++;
    if (k !== 32) begin
      n_fail++;
      $display("FAIL w_cycles: got %0d want 32", k);
    end
    wait_idle();
    rd(3'd4, d);
    n_cmp++;
    if (d !== 8'h10) begin
      n_fail++;
      $display("FAIL w_status: got %0h want 10", d);
    end
`else
    for (int i = 0; i < 200; i++) begin
      tick();
      k++;
    end
    rd(3'd4, d);
    n_cmp++;
    if (d !== 8'h01 || k !== 200) begin
      n_fail++;
      $display("FAIL w_hold: got %0h want 01", d);
    end
    wr(3'd0, 8'h02);
    wait_idle();
`endif
    rd(3'd5, d);
    n_cmp++;
    if (d !== 8'd4) begin
      n_fail++;
      $display("FAIL w_frame: got %0d want 4", d);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    n_rst  = 0;
    n_busy = 0;
    n_rden = 0;
    n_wren = 0;
    n_sel  = 0;
    sel_seen = '0;
    io.cfg_wren  = 1'b0;
    io.cfg_rden  = 1'b0;
    io.cfg_addr  = '0;
    io.cfg_wdata = '0;
    io.sse_select_ready = 1'b1;
    io.sse_in_ready     = 1'b1;
    io.src_valid        = 1'b0;
    io.sse_out_valid    = 1'b0;
    io.dst_full         = 1'b0;
    test_reset();
    test_regs();
    test_basic();
    test_len_zero();
    test_overflow();
    test_stall();
    test_abort();
    test_wdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
